// File: rtl/hash_table_pkg.sv
// Shared types and hashing for the hash-table pipeline.
// Command, pipeline-data and head-RAM record formats live here.
package hash_table;

    localparam int unsigned KEY_WIDTH      = 32;
    localparam int unsigned VALUE_WIDTH    = 16;
    localparam int unsigned BUCKET_WIDTH   = 8;
    localparam int unsigned HEAD_PTR_WIDTH = 10;
    localparam string       HASH_TYPE      = "dummy";

    localparam int unsigned NUM_SLICES = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;

    typedef enum logic [1:0] {OpSearch, OpInsert, OpDelete, OpNop} ht_opcode_t;

    typedef struct packed {
        ht_opcode_t             opcode;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

    typedef struct packed {
        ht_command_t               cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    // "xorfold" XORs every BUCKET_WIDTH slice; the shift zero-pads the last one.
    function automatic logic [BUCKET_WIDTH-1:0] calc_bucket(input logic [KEY_WIDTH-1:0] key,
                                                            input string hash_type = HASH_TYPE);
        logic [BUCKET_WIDTH-1:0] h;
        logic [KEY_WIDTH-1:0]    k;
        h = '0;
        k = key;
        if (hash_type == "xorfold") begin
            for (int i = 0; i < int'(NUM_SLICES); i++) begin
                h = h ^ k[BUCKET_WIDTH-1:0];
                k = k >> BUCKET_WIDTH;
            end
        end else begin
            h = key[BUCKET_WIDTH-1:0];
        end
        return h;
    endfunction

endpackage

// File: rtl/ht_head_table_ram.sv
// Simple dual-port head RAM: one write port, one synchronous read port.
// Read-first: a same-address write in the same cycle returns the old word.
module ht_head_ram #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/ht_head_table.sv
// Hash-table front stage: hashes the key, reads the bucket head pointer and hands
// {cmd, bucket, head} downstream, forwarding head updates so no stale head escapes.
module ht_head_table
    import hash_table::*;
#(
    parameter string HashType = HASH_TYPE
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  ht_command_t             cmd_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    output ht_pdata_t               pdata_o,
    output logic                    pdata_valid_o,
    input  logic                    pdata_ready_i,
    input  logic                    head_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] head_wr_bucket_i,
    input  head_ram_data_t          head_wr_data_i,
    output logic                    init_done_o
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                  state_q;
    logic [BUCKET_WIDTH-1:0] init_cnt_q;
    logic                    s1_valid_q;
    ht_command_t             s1_cmd_q;
    logic [BUCKET_WIDTH-1:0] s1_bucket_q;
    logic                    s2_valid_q;
    ht_pdata_t               s2_pdata_q;
    logic                    fwd_val_q;
    head_ram_data_t          fwd_data_q;

    logic [BUCKET_WIDTH-1:0] in_bucket, rd_addr, ram_waddr;
    logic                    s2_adv, accept, ram_we, wr_run;
    logic                    wr_hit_rd, wr_hit_s1, wr_hit_s2;
    head_ram_data_t          ram_wdata, ram_rdata, s1_head;

    always_comb begin
        in_bucket   = calc_bucket(cmd_i.key, HashType);
        s2_adv      = ~s2_valid_q | pdata_ready_i;
        cmd_ready_o = init_done_o & (~s1_valid_q | s2_adv);
        accept      = cmd_valid_i & cmd_ready_o;
        // While s1 stalls the RAM keeps re-reading its bucket, so dout tracks writes.
        rd_addr     = accept ? in_bucket : s1_bucket_q;
        wr_run      = head_wr_en_i & init_done_o;
        wr_hit_rd   = wr_run & (head_wr_bucket_i == rd_addr);
        wr_hit_s1   = wr_run & (head_wr_bucket_i == s1_bucket_q);
        wr_hit_s2   = wr_run & (head_wr_bucket_i == s2_pdata_q.bucket);
        ram_we      = ~init_done_o | head_wr_en_i;
        ram_waddr   = init_done_o ? head_wr_bucket_i : init_cnt_q;
        ram_wdata   = init_done_o ? head_wr_data_i : '0;
        if (wr_hit_s1) begin
            s1_head = head_wr_data_i;
        end else if (fwd_val_q) begin
            s1_head = fwd_data_q;
        end else begin
            s1_head = ram_rdata;
        end
    end

    ht_head_ram #(
        .DATA_WIDTH($bits(head_ram_data_t)),
        .ADDR_WIDTH(BUCKET_WIDTH)
    ) u_head_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_o <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_cmd_q    <= '0;
            s1_bucket_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_pdata_q  <= '0;
            fwd_val_q   <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (&init_cnt_q) begin
                        state_q     <= StRun;
                        init_done_o <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        s1_valid_q  <= 1'b1;
                        s1_cmd_q    <= cmd_i;
                        s1_bucket_q <= in_bucket;
                    end else if (s2_adv) begin
                        s1_valid_q <= 1'b0;
                    end

                    // Covers the read-first hole: the RAM returns pre-write data.
                    if (wr_hit_rd) begin
                        fwd_val_q  <= 1'b1;
                        fwd_data_q <= head_wr_data_i;
                    end else if (accept) begin
                        fwd_val_q <= 1'b0;
                    end

                    if (s1_valid_q && s2_adv) begin
                        s2_valid_q              <= 1'b1;
                        s2_pdata_q.cmd          <= s1_cmd_q;
                        s2_pdata_q.bucket       <= s1_bucket_q;
                        s2_pdata_q.head_ptr     <= s1_head.ptr;
                        s2_pdata_q.head_ptr_val <= s1_head.ptr_val;
                    end else if (s2_adv) begin
                        s2_valid_q <= 1'b0;
                    end else if (wr_hit_s2) begin
                        s2_pdata_q.head_ptr     <= head_wr_data_i.ptr;
                        s2_pdata_q.head_ptr_val <= head_wr_data_i.ptr_val;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign pdata_o       = s2_pdata_q;
    assign pdata_valid_o = s2_valid_q;

endmodule

// File: tb/tb_ht_head_table.sv
// Randomised bench for ht_head_table against a table-plus-queue reference model.
// A second instance exercises the xorfold hash.
module tb_ht_head_table;
    import hash_table::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ht_command_t             cmd;
    logic                    cmd_valid, cmd_ready, pdata_valid, pdata_ready, init_done;
    ht_pdata_t               pdata;
    logic                    wr_en;
    logic [BUCKET_WIDTH-1:0] wr_bucket;
    head_ram_data_t          wr_data;

    ht_command_t             cmd_x;
    logic                    cmd_valid_x, cmd_ready_x, pdata_valid_x, pdata_ready_x, init_done_x;
    ht_pdata_t               pdata_x;
    logic                    wr_en_x;
    logic [BUCKET_WIDTH-1:0] wr_bucket_x;
    head_ram_data_t          wr_data_x;

    ht_head_table u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_i            (cmd),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .pdata_o          (pdata),
        .pdata_valid_o    (pdata_valid),
        .pdata_ready_i    (pdata_ready),
        .head_wr_en_i     (wr_en),
        .head_wr_bucket_i (wr_bucket),
        .head_wr_data_i   (wr_data),
        .init_done_o      (init_done)
    );

    ht_head_table #(.HashType("xorfold")) u_dut_x (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_i            (cmd_x),
        .cmd_valid_i      (cmd_valid_x),
        .cmd_ready_o      (cmd_ready_x),
        .pdata_o          (pdata_x),
        .pdata_valid_o    (pdata_valid_x),
        .pdata_ready_i    (pdata_ready_x),
        .head_wr_en_i     (wr_en_x),
        .head_wr_bucket_i (wr_bucket_x),
        .head_wr_data_i   (wr_data_x),
        .init_done_o      (init_done_x)
    );

    typedef struct {
        ht_command_t cmd;
        int          edge_no;
    } exp_t;

    exp_t                      q[$];
    logic [HEAD_PTR_WIDTH-1:0] m_ptr [256];
    bit                        m_val [256];
    int                        edge_cnt;
    bit                        init_done_m;
    int                        n_checks;
    int                        n_fail;

    function automatic logic [7:0] model_bucket(input logic [31:0] key, input bit xorfold);
        int b;
        if (!xorfold) return 8'(key % 256);
        b = 0;
        for (int i = 0; i < 4; i++) b = b ^ int'((key >> (8 * i)) & 32'hFF);
        return 8'(b);
    endfunction

    function automatic ht_command_t mk_cmd(input logic [31:0] key);
        ht_command_t c;
        c.opcode = OpSearch;
        c.key    = key;
        c.value  = 16'(key ^ 32'h5A5A);
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: checks ready, applies the edge to the model, then checks the output stage.
    task automatic tick();
        bit         acc, fire, exp_v;
        logic [7:0] b;
        #1;
        check_eq("cmd_ready", 64'(cmd_ready), 64'(init_done_m && (q.size() < 2 || pdata_ready)));
        acc  = cmd_valid && cmd_ready;
        fire = pdata_valid && pdata_ready;
        @(posedge clk);
        edge_cnt++;
        if (wr_en && init_done_m) begin
            m_ptr[wr_bucket] = wr_data.ptr;
            m_val[wr_bucket] = wr_data.ptr_val;
        end
        if (fire && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back('{cmd, edge_cnt});
        #1;
        exp_v = (q.size() > 0) && (q[0].edge_no < edge_cnt);
        check_eq("pdata_valid", 64'(pdata_valid), 64'(exp_v));
        if (pdata_valid && exp_v) begin
            b = model_bucket(q[0].cmd.key, 1'b0);
            check_eq("pdata_cmd", 64'(pdata.cmd), 64'(q[0].cmd));
            check_eq("pdata_bucket", 64'(pdata.bucket), 64'(b));
            check_eq("pdata_head_ptr", 64'(pdata.head_ptr), 64'(m_ptr[b]));
            check_eq("pdata_head_val", 64'(pdata.head_ptr_val), 64'(m_val[b]));
        end
    endtask

    task automatic run_init();
        int n;
        n           = 0;
        init_done_m = 1'b0;
        q.delete();
        for (int i = 0; i < 256; i++) begin
            m_ptr[i] = '0;
            m_val[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done) break;
            check_eq("ready_during_init", 64'(cmd_ready), 64'(0));
        end
        check_eq("init_cycles", 64'(n), 64'(256));
        init_done_m = 1'b1;
    endtask

    task automatic send(input logic [31:0] key);
        cmd       = mk_cmd(key);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0]             keys3 [3];
        logic [BUCKET_WIDTH-1:0] bsel [4];
        int                      idx, sz;
        n_checks = 0;
        n_fail   = 0;
        edge_cnt = 0;
        cmd = '0; cmd_valid = 1'b0; pdata_ready = 1'b1;
        wr_en = 1'b0; wr_bucket = '0; wr_data = '0;
        cmd_x = '0; cmd_valid_x = 1'b0; pdata_ready_x = 1'b1;
        wr_en_x = 1'b0; wr_bucket_x = '0; wr_data_x = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pdata_valid", 64'(pdata_valid), 64'(0));
        check_eq("rst_init_done", 64'(init_done), 64'(0));
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check_eq("rst_pdata_zero", 64'(pdata != '0), 64'(0));

        // Writes and commands offered during INIT must be ignored.
        wr_en = 1'b1; wr_bucket = 8'h00; wr_data = '{ptr: 10'h1FF, ptr_val: 1'b1};
        cmd = mk_cmd(32'h12); cmd_valid = 1'b1;
        run_init();
        wr_en = 1'b0; cmd_valid = 1'b0;

        send(32'h0);
        check_eq("init_wr_ignored", 64'(pdata.head_ptr_val), 64'(0));
        tick();

        send(32'h0000_0012);
        check_eq("t1_valid", 64'(pdata_valid), 64'(1));
        check_eq("t1_bucket", 64'(pdata.bucket), 64'(8'h12));
        check_eq("t1_head_val", 64'(pdata.head_ptr_val), 64'(0));
        tick();

        wr_en = 1'b1; wr_bucket = 8'h12; wr_data = '{ptr: 10'h3A, ptr_val: 1'b1};
        tick();
        wr_en = 1'b0;
        repeat (3) tick();
        send(32'h0000_0112);
        check_eq("t3_head_ptr", 64'(pdata.head_ptr), 64'(10'h3A));
        check_eq("t3_head_val", 64'(pdata.head_ptr_val), 64'(1));
        tick();

        cmd = mk_cmd(32'h12); cmd_valid = 1'b1;
        wr_en = 1'b1; wr_bucket = 8'h12; wr_data = '{ptr: 10'h05, ptr_val: 1'b1};
        tick();
        cmd_valid = 1'b0; wr_data = '{ptr: 10'h06, ptr_val: 1'b1};
        tick();
        wr_en = 1'b0;
        check_eq("t4_head_ptr", 64'(pdata.head_ptr), 64'(10'h06));
        tick();

        // Backpressure: three commands, five stalled cycles, write to the stalled s2 bucket.
        keys3[0] = 32'h21; keys3[1] = 32'h22; keys3[2] = 32'h23;
        idx = 0;
        pdata_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cmd_valid = (idx < 3);
            cmd       = mk_cmd(keys3[idx < 3 ? idx : 2]);
            wr_en     = (c == 2);
            wr_bucket = 8'h21;
            wr_data   = '{ptr: 10'h2AA, ptr_val: 1'b1};
            sz = q.size();
            tick();
            if (q.size() > sz) idx++;
        end
        wr_en = 1'b0;
        check_eq("t5_s2_head_updated", 64'(pdata.head_ptr), 64'(10'h2AA));
        check_eq("t5_accepted_two", 64'(idx), 64'(2));
        pdata_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 3 || q.size() > 0); c++) begin
            cmd_valid = (idx < 3);
            cmd       = mk_cmd(keys3[idx < 3 ? idx : 2]);
            sz = q.size();
            tick();
            if (cmd_valid && (q.size() > sz || (q.size() == sz && pdata_valid))) idx++;
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        check_eq("t5_drained", 64'(q.size()), 64'(0));

        // Random traffic over a few colliding buckets.
        bsel[0] = 8'h12; bsel[1] = 8'h34; bsel[2] = 8'h55; bsel[3] = 8'hFF;
        for (int c = 0; c < 2000; c++) begin
            cmd_valid   = ($urandom % 3) != 0;
            cmd         = mk_cmd(($urandom & 32'hFFFF_FF00) | 32'(bsel[$urandom % 4]));
            cmd.opcode  = ht_opcode_t'($urandom % 4);
            pdata_ready = ($urandom % 3) != 0;
            wr_en       = ($urandom % 3) == 0;
            wr_bucket   = bsel[$urandom % 4];
            wr_data     = head_ram_data_t'($urandom);
            tick();
        end
        cmd_valid = 1'b0; wr_en = 1'b0; pdata_ready = 1'b1;
        repeat (4) tick();
        check_eq("rand_drained", 64'(q.size()), 64'(0));

        // xorfold hash on the second instance.
        cmd_x = mk_cmd(32'hA1B2_C3D4); cmd_valid_x = 1'b1;
        #1;
        check_eq("xor_ready", 64'(cmd_ready_x), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid_x = 1'b0;
        check_eq("xor_valid_early", 64'(pdata_valid_x), 64'(0));
        @(posedge clk);
        #1;
        check_eq("xor_valid", 64'(pdata_valid_x), 64'(1));
        check_eq("xor_bucket_model", 64'(pdata_x.bucket), 64'(model_bucket(32'hA1B2_C3D4, 1'b1)));
        check_eq("xor_bucket_const", 64'(pdata_x.bucket), 64'(8'h04));
        check_eq("xor_head_val", 64'(pdata_x.head_ptr_val), 64'(0));

        // Reset in the middle of a stream.
        cmd = mk_cmd(32'h77); cmd_valid = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(pdata_valid), 64'(0));
        check_eq("midrst_ready", 64'(cmd_ready), 64'(0));
        check_eq("midrst_init_done", 64'(init_done), 64'(0));
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        run_init();
        send(32'h12);
        check_eq("post_rst_bucket", 64'(pdata.bucket), 64'(8'h12));
        check_eq("post_rst_head_cleared", 64'(pdata.head_ptr_val), 64'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
